// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, fetch FSM state type and address helper
package mips_pkg;

    localparam int          OP_W             = 6;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_ST = 2'd0,
        HOLD_ST  = 2'd1,
        DROP_ST  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline stage register with reset > flush > stall > load priority
module if_id_reg #(
    parameter int                  DATA_W = 64,
    parameter logic [DATA_W-1:0]   BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_valid,
    output logic [DATA_W-1:0] q_data,
    output logic              q_valid
);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            q_data  <= BUBBLE;
            q_valid <= 1'b0;
        end else if (!stall) begin
            // An invalid load still writes the bubble value so stale data never lingers.
            q_data  <= d_valid ? d_data : BUBBLE;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with imem handshake and IF/ID register (option: FETCH_PERF_CNT_EN)
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic [31:0]     instr_d,
    output logic [31:0]     pcplus4_d,
    output logic [OP_W-1:0] op_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_count,
    output logic [31:0]     bubble_count,
`endif
    output logic            valid_d
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_f;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc4;
    logic         load_valid;
    logic [31:0]  load_instr;
    logic [31:0]  load_pc4;

    assign pc_plus4  = pc_f + 32'd4;
    assign imem_addr = pc_f;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FETCH_ST;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH_ST: begin
                if (redirect && !imem_ack)           state_next = DROP_ST;
                else if (imem_ack && !redirect && stall_d) state_next = HOLD_ST;
            end
            HOLD_ST:  if (redirect || !stall_d)   state_next = FETCH_ST;
            DROP_ST:  if (imem_ack)               state_next = FETCH_ST;
            default:                              state_next = FETCH_ST;
        endcase
    end

    always_comb begin
        imem_req   = reset_n && (state != HOLD_ST);
        load_valid = 1'b0;
        load_instr = NOP_INSTR;
        load_pc4   = 32'h0;
        if (state == FETCH_ST && imem_ack && !redirect) begin
            load_valid = 1'b1;
            load_instr = imem_rdata;
            load_pc4   = pc_plus4;
        end else if (state == HOLD_ST && !redirect) begin
            load_valid = 1'b1;
            load_instr = hold_instr;
            load_pc4   = hold_pc4;
        end
    end

    // PC_F keeps the in-flight address during DROP; the redirect target waits in `target`.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_f       <= RESET_PC;
            target     <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= 32'h0;
        end else begin
            case (state)
                FETCH_ST: begin
                    if (redirect) begin
                        if (imem_ack) pc_f   <= word_align(redirect_pc);
                        else          target <= word_align(redirect_pc);
                    end else if (imem_ack) begin
                        pc_f       <= pc_plus4;
                        hold_instr <= imem_rdata;
                        hold_pc4   <= pc_plus4;
                    end
                end
                HOLD_ST: if (redirect) pc_f <= word_align(redirect_pc);
                DROP_ST: begin
                    if (imem_ack)      pc_f   <= redirect ? word_align(redirect_pc) : target;
                    else if (redirect) target <= word_align(redirect_pc);
                end
                default: pc_f <= pc_f;
            endcase
        end
    end

    if_id_reg #(
        .DATA_W (64),
        .BUBBLE ({NOP_INSTR, 32'h0})
    ) u_if_id (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall_d),
        .flush   (flush_d),
        .d_data  ({load_instr, load_pc4}),
        .d_valid (load_valid),
        .q_data  ({instr_d, pcplus4_d}),
        .q_valid (valid_d)
    );

    assign op_d = instr_d[31:32-OP_W];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else if (!stall_d) begin
            if (!flush_d && load_valid) fetch_count  <= fetch_count + 32'd1;
            else                        bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        flush_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic [5:0]  op_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
    logic [31:0] fc_before;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_d     (instr_d),
        .pcplus4_d   (pcplus4_d),
        .op_d        (op_d),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .bubble_count(bubble_count),
`endif
        .valid_d     (valid_d)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic stall,
                       input logic flush, input logic redir, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stall; v.flush = flush;
        v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, check the decoded request, then the registered IF/ID after the edge.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_op;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        stall_d     = v.stall;
        flush_d     = v.flush;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #2;
        chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, v.e_req});
        if (v.e_req) chk({tag, " imem_addr"}, imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        exp_op = {26'h0, v.e_instr[31:26]};
        chk({tag, " instr_d"}, instr_d, v.e_instr);
        chk({tag, " pcplus4_d"}, pcplus4_d, v.e_pc4);
        chk({tag, " valid_d"}, {31'h0, valid_d}, {31'h0, v.e_valid});
        chk({tag, " op_d"}, {26'h0, op_d}, exp_op);
    endtask

    initial begin
        vec_t w;
        // zero-wait memory
        add(1, 32'h8C08_0004, 0,0,0, 0,     1, 32'h0,   32'h8C08_0004, 32'h4,   1);
        add(1, 32'h1111_1111, 0,0,0, 0,     1, 32'h4,   32'h1111_1111, 32'h8,   1);
        add(1, 32'h2222_2222, 0,0,0, 0,     1, 32'h8,   32'h2222_2222, 32'hC,   1);
        // three-cycle latency
        add(0, 32'h0,         0,0,0, 0,     1, 32'hC,   32'h0,         32'h0,   0);
        add(0, 32'h0,         0,0,0, 0,     1, 32'hC,   32'h0,         32'h0,   0);
        add(1, 32'h3333_3333, 0,0,0, 0,     1, 32'hC,   32'h3333_3333, 32'h10,  1);
        add(0, 32'h0,         0,0,0, 0,     1, 32'h10,  32'h0,         32'h0,   0);
        add(0, 32'h0,         0,0,0, 0,     1, 32'h10,  32'h0,         32'h0,   0);
        add(1, 32'h4444_4444, 0,0,0, 0,     1, 32'h10,  32'h4444_4444, 32'h14,  1);
        // stall during ack -> HOLD, no refetch
        add(1, 32'h5555_5555, 0,0,0, 0,     1, 32'h14,  32'h5555_5555, 32'h18,  1);
        add(1, 32'h6666_6666, 1,0,0, 0,     1, 32'h18,  32'h5555_5555, 32'h18,  1);
        add(0, 32'h0,         1,0,0, 0,     0, 32'h0,   32'h5555_5555, 32'h18,  1);
        add(0, 32'h0,         0,0,0, 0,     0, 32'h0,   32'h6666_6666, 32'h1C,  1);
        // redirect while request waits -> DROP
        add(0, 32'h0,         0,0,1, 32'h103, 1, 32'h1C, 32'h0,        32'h0,   0);
        add(0, 32'h0,         0,0,0, 0,     1, 32'h1C,  32'h0,         32'h0,   0);
        add(1, 32'hDEAD_BEEF, 0,0,0, 0,     1, 32'h1C,  32'h0,         32'h0,   0);
        add(1, 32'h7777_7777, 0,0,0, 0,     1, 32'h100, 32'h7777_7777, 32'h104, 1);
        // redirect with ack in the same cycle
        add(1, 32'hBAD0_BAD0, 0,0,1, 32'h200, 1, 32'h104, 32'h0,       32'h0,   0);
        add(1, 32'h8888_8888, 0,0,0, 0,     1, 32'h200, 32'h8888_8888, 32'h204, 1);
        // flush and stall together
        add(1, 32'h9999_9999, 1,1,0, 0,     1, 32'h204, 32'h0,         32'h0,   0);
        add(0, 32'h0,         0,0,0, 0,     0, 32'h0,   32'h9999_9999, 32'h208, 1);
        add(1, 32'hAAAA_AAAA, 0,0,0, 0,     1, 32'h208, 32'hAAAA_AAAA, 32'h20C, 1);
        // redirect in HOLD discards the buffer
        add(1, 32'hBBBB_BBBB, 1,0,0, 0,     1, 32'h20C, 32'hAAAA_AAAA, 32'h20C, 1);
        add(0, 32'h0,         0,0,1, 32'h300, 0, 32'h0,  32'h0,        32'h0,   0);
        add(1, 32'hCCCC_CCCC, 0,0,0, 0,     1, 32'h300, 32'hCCCC_CCCC, 32'h304, 1);
        // second redirect in DROP overwrites the target
        add(0, 32'h0,         0,0,1, 32'h400, 1, 32'h304, 32'h0,       32'h0,   0);
        add(0, 32'h0,         0,0,1, 32'h500, 1, 32'h304, 32'h0,       32'h0,   0);
        add(1, 32'hEEEE_EEEE, 0,0,0, 0,     1, 32'h304, 32'h0,         32'h0,   0);
        add(1, 32'h1212_1212, 0,0,0, 0,     1, 32'h500, 32'h1212_1212, 32'h504, 1);

        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req", {31'h0, imem_req}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset valid_d", {31'h0, valid_d}, 32'h0);
        chk("reset instr_d", instr_d, 32'h0);
        chk("reset pcplus4_d", pcplus4_d, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // PC wrap at the top of the address space
        w = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h504, 32'h0, 32'h0, 1'b0};
        apply(w, "wrap_redirect");
`ifdef FETCH_PERF_CNT_EN
        fc_before = fetch_count;
`endif
        w = '{1'b1, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h2345_6789, 32'h0, 1'b1};
        apply(w, "wrap_fetch");
`ifdef FETCH_PERF_CNT_EN
        chk("wrap fetch_count", fetch_count, fc_before + 32'd1);
`endif
        imem_ack = 1'b0;
        #2;
        chk("wrap next imem_addr", imem_addr, 32'h0);
        chk("wrap next imem_req", {31'h0, imem_req}, 32'h1);

        // reset asserted mid-stream drops the request immediately
        reset_n = 1'b0;
        #1;
        chk("midreset imem_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        chk("midreset valid_d", {31'h0, valid_d}, 32'h0);
        chk("midreset imem_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
